// File: rtl/beat_pkg.sv
// Shared types and constants for the beat tempo tracker.
package beat_pkg;

    typedef enum logic [2:0] {IDLE, HIST, CMP, IOI, DIV, OUT} state_t;

    localparam int unsigned FLUX_W_DEF     = 70;
    localparam int unsigned HIST_DEPTH_DEF = 16;
    localparam int unsigned IOI_DEPTH_DEF  = 8;

    localparam logic [7:0]  MIN_IOI = 8'd12;
    localparam logic [7:0]  MAX_IOI = 8'd60;
    localparam logic [15:0] BPM_NUM = 16'd22500;

    localparam int unsigned HIST_SUM_W = FLUX_W_DEF + $clog2(HIST_DEPTH_DEF);
    localparam int unsigned IOI_SUM_W  = 8 + $clog2(IOI_DEPTH_DEF);

endpackage

// File: rtl/beat_tempo_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, start/busy/done handshake.
module seq_divider #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W:0]       rem;
    logic [W:0]       shifted;
    logic [CNT_W-1:0] cnt;

    // Dividend bits are shifted out of the quotient register as quotient bits shift in.
    always_comb begin
        shifted = {rem[W-1:0], quotient[W-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            quotient <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem      <= '0;
                quotient <= dividend;
                cnt      <= CNT_W'(W);
                busy     <= 1'b1;
            end else if (busy) begin
                if (shifted >= {1'b0, divisor}) begin
                    rem      <= shifted - {1'b0, divisor};
                    quotient <= {quotient[W-2:0], 1'b1};
                end else begin
                    rem      <= shifted;
                    quotient <= {quotient[W-2:0], 1'b0};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/beat_tempo_tracker.sv
// Onset detection against a scaled running mean of flux, IOI averaging and BPM conversion.
module beat_tempo_tracker
    import beat_pkg::*;
#(
    parameter int unsigned FLUX_W         = FLUX_W_DEF,
    parameter int unsigned HIST_DEPTH     = HIST_DEPTH_DEF,
    parameter int unsigned THRESH_NUM     = 12,
    parameter int unsigned REFRACT_FRAMES = 4,
    parameter int unsigned IOI_DEPTH      = IOI_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flux_valid,
    input  logic [FLUX_W-1:0] flux_value,
    output logic              onset,
    output logic [7:0]        bpm,
    output logic              bpm_valid,
    output logic              bpm_locked,
    output logic [FLUX_W+3:0] threshold_out,
    output logic              overrun
);

    localparam int unsigned HIDX_W = $clog2(HIST_DEPTH);
    localparam int unsigned IIDX_W = $clog2(IOI_DEPTH);
    localparam int unsigned THR_W  = FLUX_W + 4;
    localparam int unsigned DIV_W  = 16;

    state_t state_q, state_d;

    logic                  flux_valid_q;
    logic                  event_w;
    logic [FLUX_W-1:0]     flux_q;
    logic [FLUX_W-1:0]     hist [HIST_DEPTH];
    logic [HIDX_W-1:0]     hidx;
    logic [HIST_SUM_W-1:0] hist_sum;
    logic [HIST_SUM_W-1:0] sum_pre;
    logic [HIDX_W:0]       frames_seen;
    logic                  full_pre;

    logic [7:0]            since;
    logic                  have_onset;
    logic                  hit_q;
    logic [7:0]            ioi_ring [IOI_DEPTH];
    logic [IIDX_W-1:0]     iidx;
    logic [IIDX_W:0]       ioi_cnt;
    logic [IIDX_W:0]       cnt_next;
    logic [IOI_SUM_W-1:0]  ioi_sum;

    logic [FLUX_W-1:0]     mean;
    logic [THR_W-1:0]      thr_prod;
    logic [THR_W-1:0]      thr;
    logic                  hit;
    logic                  push;
    logic                  go_div;

    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic [DIV_W-1:0]      div_q;

    assign event_w    = flux_valid && !flux_valid_q;
    assign bpm_locked = (ioi_cnt == (IIDX_W+1)'(IOI_DEPTH));

    seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (BPM_NUM),
        .divisor  (DIV_W'(ioi_sum)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    // sum_pre/full_pre snapshot the history before this frame was written in HIST.
    always_comb begin
        mean     = sum_pre[HIST_SUM_W-1:HIDX_W];
        thr_prod = THR_W'(mean) * THR_W'(THRESH_NUM);
        thr      = thr_prod >> 3;
        hit      = full_pre && (THR_W'(flux_q) > thr) &&
                   ((since >= 8'(REFRACT_FRAMES)) || !have_onset);
        push     = hit_q && have_onset && (since >= MIN_IOI) && (since <= MAX_IOI);
        cnt_next = ioi_cnt;
        if (push && !bpm_locked)
            cnt_next = ioi_cnt + (IIDX_W+1)'(1);
        go_div   = push && (cnt_next == (IIDX_W+1)'(IOI_DEPTH));
    end

    // Divider starts on DIV entry so it sees the ioi_sum already updated in IOI.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: if (event_w) state_d = HIST;
            HIST: state_d = CMP;
            CMP:  state_d = IOI;
            IOI:  state_d = go_div ? DIV : IDLE;
            DIV: begin
                div_start = !div_busy && !div_done;
                if (div_done) state_d = OUT;
            end
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            flux_valid_q  <= 1'b0;
            flux_q        <= '0;
            hidx          <= '0;
            hist_sum      <= '0;
            sum_pre       <= '0;
            frames_seen   <= '0;
            full_pre      <= 1'b0;
            since         <= '0;
            have_onset    <= 1'b0;
            hit_q         <= 1'b0;
            iidx          <= '0;
            ioi_cnt       <= '0;
            ioi_sum       <= '0;
            onset         <= 1'b0;
            bpm           <= '0;
            bpm_valid     <= 1'b0;
            threshold_out <= '0;
            overrun       <= 1'b0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            for (int unsigned i = 0; i < IOI_DEPTH; i++) ioi_ring[i] <= '0;
        end else begin
            state_q      <= state_d;
            flux_valid_q <= flux_valid;
            onset        <= 1'b0;
            bpm_valid    <= 1'b0;
            if (event_w) begin
                if (state_q == IDLE) flux_q <= flux_value;
                else                 overrun <= 1'b1;
            end
            case (state_q)
                HIST: begin
                    sum_pre    <= hist_sum;
                    full_pre   <= (frames_seen == (HIDX_W+1)'(HIST_DEPTH));
                    hist_sum   <= hist_sum - HIST_SUM_W'(hist[hidx]) + HIST_SUM_W'(flux_q);
                    hist[hidx] <= flux_q;
                    hidx       <= hidx + HIDX_W'(1);
                    if (frames_seen != (HIDX_W+1)'(HIST_DEPTH))
                        frames_seen <= frames_seen + (HIDX_W+1)'(1);
                    if (since != '1) since <= since + 8'd1;
                end
                CMP: begin
                    threshold_out <= thr;
                    hit_q         <= hit;
                    onset         <= hit;
                end
                IOI: begin
                    if (hit_q) begin
                        since      <= '0;
                        have_onset <= 1'b1;
                        if (push) begin
                            ioi_ring[iidx] <= since;
                            iidx           <= iidx + IIDX_W'(1);
                            ioi_sum        <= ioi_sum - IOI_SUM_W'(ioi_ring[iidx]) + IOI_SUM_W'(since);
                            ioi_cnt        <= cnt_next;
                        end
                    end else if (since >= (MAX_IOI << 1)) begin
                        iidx    <= '0;
                        ioi_cnt <= '0;
                        ioi_sum <= '0;
                        for (int unsigned i = 0; i < IOI_DEPTH; i++) ioi_ring[i] <= '0;
                    end
                end
                OUT: begin
                    bpm       <= (div_q > DIV_W'(255)) ? 8'hFF : div_q[7:0];
                    bpm_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beat_tempo_tracker.sv
// Randomised scoreboard bench for beat_tempo_tracker against a frame-level reference model.
module tb_beat_tempo_tracker;

    localparam int FW = 70;
    localparam int TW = 74;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flux_valid = 1'b0;
    logic [FW-1:0] flux_value = '0;
    logic          onset;
    logic [7:0]    bpm;
    logic          bpm_valid;
    logic          bpm_locked;
    logic [TW-1:0] threshold_out;
    logic          overrun;

    beat_tempo_tracker #(
        .FLUX_W(70), .HIST_DEPTH(16), .THRESH_NUM(12), .REFRACT_FRAMES(4), .IOI_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .flux_valid(flux_valid), .flux_value(flux_value),
        .onset(onset), .bpm(bpm), .bpm_valid(bpm_valid), .bpm_locked(bpm_locked),
        .threshold_out(threshold_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int bv_count = 0;

    task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct { int cyc; logic [TW-1:0] thr; } onset_exp_t;
    typedef struct { int dl;  logic [7:0] bpm; }     bpm_exp_t;
    onset_exp_t oq[$];
    bpm_exp_t   bq[$];
    onset_exp_t oe;
    bpm_exp_t   be;

    // Reference model: history of raw frames, list of accepted IOIs.
    logic [FW-1:0] hq[$];
    int            iq[$];
    int            m_since;
    bit            m_have;
    logic [TW-1:0] m_thr;
    logic [7:0]    m_bpm;
    bit            m_overrun;

    task automatic model_reset();
        hq.delete(); iq.delete();
        m_since = 0; m_have = 0; m_thr = '0; m_bpm = '0; m_overrun = 0;
    endtask

    task automatic model_frame(input logic [FW-1:0] v, input int t, input bit abort, output bit will_div);
        logic [TW+1:0] s, thr;
        bit hit;
        int isum, b;
        will_div = 0;
        s = '0;
        foreach (hq[i]) s += (TW+2)'(hq[i]);
        thr   = ((s / 16) * 12) / 8;
        m_thr = thr[TW-1:0];
        if (m_since < 255) m_since++;
        hit = (hq.size() == 16) && ((TW+2)'(v) > thr) && (m_since >= 4 || !m_have);
        hq.push_back(v);
        if (hq.size() > 16) void'(hq.pop_front());
        if (hit) begin
            oq.push_back('{t + 3, m_thr});
            if (m_have && m_since >= 12 && m_since <= 60) begin
                iq.push_back(m_since);
                if (iq.size() > 8) void'(iq.pop_front());
                if (iq.size() == 8) begin
                    isum = 0;
                    foreach (iq[i]) isum += iq[i];
                    b = 22500 / isum;
                    if (b > 255) b = 255;
                    will_div = 1;
                    if (!abort) begin
                        bq.push_back('{t + 24, 8'(b)});
                        m_bpm = 8'(b);
                    end
                end
            end
            m_since = 0;
            m_have  = 1;
        end else if (m_since >= 120) begin
            iq.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_onset"}, TW'(onset), '0);
        check({tag, "_bpm"}, TW'(bpm), '0);
        check({tag, "_bpm_valid"}, TW'(bpm_valid), '0);
        check({tag, "_bpm_locked"}, TW'(bpm_locked), '0);
        check({tag, "_threshold"}, threshold_out, '0);
        check({tag, "_overrun"}, TW'(overrun), '0);
    endtask

    // mode 0: normal, 1: reset during the division this frame triggers, 2: second edge while busy
    task automatic send(input logic [FW-1:0] v, input int hold, input int gap, input int mode);
        bit wd;
        int t;
        int bv_before;
        t = cyc;
        model_frame(v, t, mode == 1, wd);
        flux_value = v;
        flux_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 flux_valid = 1'b0;
        if (mode == 2) begin
            @(posedge clk); #1 flux_valid = 1'b1;
            @(posedge clk); #1 flux_valid = 1'b0;
            m_overrun = 1;
        end
        if (mode == 1 && wd) begin
            bv_before = bv_count;
            repeat (t + 10 - cyc) @(posedge clk);
            #1 reset = 1'b1;
            repeat (3) @(posedge clk);
            #1 check_all_zero("abort");
            model_reset();
            reset = 1'b0;
            repeat (30) @(posedge clk);
            #1 check("abort_no_bpm_valid", TW'(bv_count), TW'(bv_before));
        end else begin
            repeat (t + gap - cyc) @(posedge clk);
            #1;
            check("frame_threshold", threshold_out, m_thr);
            check("frame_locked", TW'(bpm_locked), TW'(iq.size() == 8));
            check("frame_bpm", TW'(bpm), TW'(m_bpm));
            check("frame_overrun", TW'(overrun), TW'(m_overrun));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 flux_valid = ~flux_valid;
        end
        check_all_zero("reset");
        flux_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (onset) begin
                if (oq.size() == 0) check("onset_unexpected", TW'(onset), '0);
                else begin
                    oe = oq.pop_front();
                    check("onset_cycle", TW'(cyc), TW'(oe.cyc));
                    check("onset_threshold", threshold_out, oe.thr);
                end
            end else if (oq.size() > 0 && cyc > oq[0].cyc) begin
                check("onset_missing", TW'(onset), TW'(1));
                void'(oq.pop_front());
            end
            if (bpm_valid) begin
                bv_count++;
                if (bq.size() == 0) check("bpm_valid_unexpected", TW'(bpm_valid), '0);
                else begin
                    be = bq.pop_front();
                    check("bpm_value", TW'(bpm), TW'(be.bpm));
                    check("bpm_latency", TW'(cyc <= be.dl), TW'(1));
                    check("bpm_locked_at_valid", TW'(bpm_locked), TW'(1));
                end
            end else if (bq.size() > 0 && cyc > bq[0].dl) begin
                check("bpm_valid_missing", TW'(bpm_valid), TW'(1));
                void'(bq.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] rnd;
        logic [FW-1:0] v;
        int next_spike;

        model_reset();
        do_reset();

        // Warm-up: the 16th frame may not fire even though it is huge.
        for (int i = 0; i < 15; i++) send(70'd1000, 1, 26, 0);
        send(70'd100000, 1, 26, 0);

        do_reset();
        for (int i = 0; i < 16; i++) send(70'd1000, 1, 26, 0);
        send(70'd5000, 1, 26, 0);
        check("warmup_threshold", threshold_out, TW'(1500));

        // Spikes every 20 frames: 8 accepted IOIs of 20 -> 22500/160.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 19; i++) send(70'd1000, 1, 26, 0);
            send(70'd50000, 1, 26, 0);
        end
        check("lock_bpm", TW'(bpm), TW'(140));
        check("lock_locked", TW'(bpm_locked), TW'(1));

        // Refractory suppression at 2 frames, short IOI discarded at 8 frames.
        send(70'd1000, 1, 26, 0);
        send(70'd50000, 1, 26, 0);
        for (int i = 0; i < 5; i++) send(70'd1000, 1, 26, 0);
        send(70'd50000, 1, 26, 0);
        check("short_ioi_still_locked", TW'(bpm_locked), TW'(1));

        // Loss of tempo after 2*MAX_IOI quiet frames.
        for (int i = 0; i < 120; i++) send(70'd1000, 1, 26, 0);
        check("loss_unlocked", TW'(bpm_locked), '0);
        check("loss_bpm_held", TW'(bpm), TW'(140));

        // Edge handling.
        send(70'd50000, 5, 30, 0);
        check("held_level_no_overrun", TW'(overrun), '0);
        send(70'd1000, 1, 26, 2);
        check("double_edge_overrun", TW'(overrun), TW'(1));

        // Random phase.
        next_spike = $urandom_range(10, 30);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                v = rnd[FW-1:0];
            end else if (next_spike == 0) begin
                v = FW'(40000 + $urandom_range(0, 20000));
                next_spike = $urandom_range(10, 30);
            end else begin
                v = FW'($urandom_range(900, 1100));
                next_spike--;
            end
            send(v, $urandom_range(1, 3), $urandom_range(26, 34), 0);
        end

        // Reset during the division of the locking onset.
        do_reset();
        for (int i = 0; i < 16; i++) send(70'd1000, 1, 26, 0);
        send(70'd50000, 1, 26, 0);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 19; i++) send(70'd1000, 1, 26, 0);
            send(70'd50000, 1, 26, (k == 7) ? 1 : 0);
        end

        repeat (30) @(posedge clk);
        #1;
        check("onset_queue_drained", TW'(oq.size()), '0);
        check("bpm_queue_drained", TW'(bq.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beat_tempo_tracker.md
Name: beat_tempo_tracker

Overview:
Downstream consumer of the spectral flux stage. It takes one flux value per frame and keeps a running mean over a ring-buffered history. An onset fires when flux exceeds a scaled mean, subject to a refractory window. It averages the inter-onset intervals (IOIs, counted in frames) and converts the average into an integer BPM with a multi-cycle divider.

Parameters:
- FLUX_W, 70, width of flux_value.
- HIST_DEPTH, 16, flux history length; power of 2.
- THRESH_NUM, 12, threshold = (mean*THRESH_NUM)>>3, which is 1.5x the mean.
- REFRACT_FRAMES, 4, minimum number of frames between onsets.
- MIN_IOI, 12, smallest accepted IOI in frames (about 234 BPM).
- MAX_IOI, 60, largest accepted IOI in frames (about 47 BPM).
- IOI_DEPTH, 8, number of IOIs averaged; power of 2.
- BPM_NUM, 22500, equals 60*46.875 fps*IOI_DEPTH; bpm = BPM_NUM/ioi_sum.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- flux_valid  in  1  frame flux strobe; may stay high for several cycles
- flux_value  in  FLUX_W  frame flux
- onset  out  1  one-cycle onset pulse
- bpm  out  8  latest tempo, saturated at 255
- bpm_valid  out  1  one-cycle pulse when bpm updates
- bpm_locked  out  1  level: IOI buffer full
- threshold_out  out  FLUX_W+4  current threshold (debug)
- overrun  out  1  sticky: a frame edge arrived while busy

Behaviour:
- Reset clears every output, both ring buffers, the sums, the counters, the warm-up count and the FSM state (back to IDLE).
- Reset mid-division aborts it; no bpm_valid follows.
- Frame event: rising edge of flux_valid, i.e. flux_valid=1 in cycle T and 0 in T-1. flux_value is latched at T.
- A level held high produces exactly one event.
- An edge while the FSM is not in IDLE is dropped and sets overrun. overrun clears only on reset.
- FSM states: IDLE, HIST, CMP, IOI, DIV, OUT.
- IDLE -> HIST on an event.
- HIST, at T+1:
  - hist_sum <= hist_sum - hist[idx] + flux.
  - hist[idx] <= flux; idx wraps from HIST_DEPTH-1 to 0.
  - frames_seen saturates at HIST_DEPTH.
  - Every flux, onsets included, enters the history.
- CMP, at T+2:
  - mean = hist_sum >> log2(HIST_DEPTH), using the sum before this frame.
  - thr = (mean*THRESH_NUM)>>3, registered into threshold_out.
  - hit = (frames_seen==HIST_DEPTH before this frame) && (flux > thr) && (since >= REFRACT_FRAMES || no prior onset).
  - Comparison is strict.
- onset pulses at exactly T+3 when hit.
- since: frames since last onset, 8 bits, incremented once per event, saturating at 255.
- IOI state, at T+3:
  - If hit with a prior onset and MIN_IOI <= since <= MAX_IOI: push since into the IOI ring, ioi_sum += since - oldest, ioi_cnt saturates at IOI_DEPTH.
  - An out-of-range IOI is discarded.
  - Any hit resets since to 0 and sets the prior-onset flag.
  - No hit and since reaches 2*MAX_IOI: clear the IOI ring, ioi_sum and ioi_cnt; bpm_locked <= 0; bpm holds its last value.
  - bpm_locked = (ioi_cnt == IOI_DEPTH).
  - Go to DIV if a push occurred and locked; otherwise go to IDLE.
- DIV: restoring divider, BPM_NUM / ioi_sum, 16 iterations.
  - ioi_sum >= IOI_DEPTH*MIN_IOI, so divide-by-zero cannot occur.
- OUT:
  - bpm <= min(quotient, 255), floor rounding.
  - bpm_valid pulses for one cycle, no later than T+24.
  - Return to IDLE.
- Widths:
  - hist_sum: FLUX_W + log2(HIST_DEPTH).
  - Threshold product: FLUX_W + 4.
  - ioi_sum: 8 + log2(IOI_DEPTH) bits.
  - All arithmetic is unsigned and never wraps.

Decomposition:
- Package beat_pkg holds:
  - the FSM state enum;
  - the constants MIN_IOI, MAX_IOI, BPM_NUM;
  - the localparam widths HIST_SUM_W and IOI_SUM_W.
- One sub-module, seq_divider, with start/busy/done handshake, a parameterised width and a 1-bit-per-cycle restoring algorithm.
- Both ring buffers are inferred RAM/register arrays inside the top module.

Test Plan:
- Reset: hold reset 4 cycles with flux_valid toggling -> all outputs 0, no onset, overrun=0.
- Warm-up: 15 frames of flux 1000, then a frame of 100000 as the 16th -> no onset; after 16 frames of 1000 a frame of 5000 -> onset at T+3, threshold_out=1500.
- Tempo lock:
  - Stimulus: baseline 1000 with spikes of 50000 every 20 frames, after warm-up.
  - After 9 onsets: bpm_locked=1 and bpm_valid pulse with bpm=140 (22500/160).
- Refractory/range:
  - Spike 2 frames after an onset -> suppressed, no onset.
  - Spike 8 frames after an onset -> onset pulses, but the IOI is discarded and ioi_cnt is unchanged.
- Edge handling:
  - flux_valid held high 5 cycles -> exactly one event.
  - Second edge 2 cycles after the first -> dropped, overrun=1.
- Loss/abort:
  - Lock, then 120 frames of baseline -> bpm_locked=0, bpm unchanged.
  - Reset asserted during DIV -> no bpm_valid, all outputs 0.
